// File: rtl/memory_stage.sv
// Memory pipeline stage: issues aligned loads/stores on the data bus, waits for
// completion, and registers the writeback-stage result.
module memory_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_in,
  input  logic [63:0] pc_in,
  input  logic [63:0] alu_in,
  input  logic [63:0] srcb_in,
  input  logic [4:0]  dst_in,
  input  logic        regwrite_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  msize,
  input  logic        mem_unsigned,
  input  logic        flush,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  output logic        dreq_write,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        stall_m,
  output logic        valid_out,
  output logic [63:0] pc_out,
  output logic [4:0]  dst_out,
  output logic        regwrite_out,
  output logic [63:0] result_out,
  output logic        misalign_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, stateNext;

  logic        memOp;
  logic        aligned;
  logic        captureReq;
  logic        completeReq;
  logic [7:0]  byteMask;
  logic [63:0] storeData;
  logic [63:0] loadShifted;
  logic [63:0] loadValue;

  logic [63:0] reqAddr;
  logic [1:0]  reqSize;
  logic        reqWrite;
  logic [63:0] reqData;
  logic [7:0]  reqStrobe;
  logic        reqUnsigned;
  logic [63:0] reqPc;
  logic [4:0]  reqDst;
  logic        reqRegwrite;

  assign memOp = valid_in & (mem_read | mem_write);

  always_comb begin
    aligned  = 1'b0;
    byteMask = '0;
    case (msize)
      2'd0: begin aligned = 1'b1;                 byteMask = 8'h01; end
      2'd1: begin aligned = ~alu_in[0];           byteMask = 8'h03; end
      2'd2: begin aligned = (alu_in[1:0] == '0);  byteMask = 8'h0F; end
      default: begin aligned = (alu_in[2:0] == '0); byteMask = 8'hFF; end
    endcase
  end

  assign storeData = srcb_in << {alu_in[2:0], 3'b000};

  always_comb begin
    loadShifted = dresp_data >> {reqAddr[2:0], 3'b000};
    loadValue   = loadShifted;
    case (reqSize)
      2'd0: loadValue = reqUnsigned ? {56'd0, loadShifted[7:0]}
                                    : {{56{loadShifted[7]}}, loadShifted[7:0]};
      2'd1: loadValue = reqUnsigned ? {48'd0, loadShifted[15:0]}
                                    : {{48{loadShifted[15]}}, loadShifted[15:0]};
      2'd2: loadValue = reqUnsigned ? {32'd0, loadShifted[31:0]}
                                    : {{32{loadShifted[31]}}, loadShifted[31:0]};
      default: loadValue = loadShifted;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    stall_m     = 1'b0;
    captureReq  = 1'b0;
    completeReq = 1'b0;
    case (state)
      IDLE: begin
        if (memOp && aligned && !flush) begin
          captureReq = 1'b1;
          stall_m    = 1'b1;
          stateNext  = WAIT;
        end
      end
      WAIT: begin
        // The bus request cannot be withdrawn, so a flush only detaches the result.
        if (flush) begin
          stateNext = dresp_data_ok ? IDLE : DRAIN;
        end else if (dresp_data_ok) begin
          completeReq = 1'b1;
          stateNext   = IDLE;
        end else begin
          stall_m = 1'b1;
        end
      end
      DRAIN: begin
        // Nothing can be accepted until the orphaned transfer completes.
        stall_m = valid_in;
        if (dresp_data_ok) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      reqAddr     <= '0;
      reqSize     <= '0;
      reqWrite    <= 1'b0;
      reqData     <= '0;
      reqStrobe   <= '0;
      reqUnsigned <= 1'b0;
      reqPc       <= '0;
      reqDst      <= '0;
      reqRegwrite <= 1'b0;
    end else if (captureReq) begin
      reqAddr     <= alu_in;
      reqSize     <= msize;
      reqWrite    <= mem_write;
      reqData     <= storeData;
      reqStrobe   <= byteMask << alu_in[2:0];
      reqUnsigned <= mem_unsigned;
      reqPc       <= pc_in;
      reqDst      <= dst_in;
      reqRegwrite <= regwrite_in;
    end
  end

  assign dreq_valid  = (state != IDLE);
  assign dreq_addr   = reqAddr;
  assign dreq_size   = reqSize;
  assign dreq_strobe = reqStrobe;
  assign dreq_data   = reqData;
  assign dreq_write  = reqWrite;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_out    <= 1'b0;
      pc_out       <= '0;
      dst_out      <= '0;
      regwrite_out <= 1'b0;
      result_out   <= '0;
      misalign_out <= 1'b0;
    end else begin
      valid_out    <= 1'b0;
      regwrite_out <= 1'b0;
      misalign_out <= 1'b0;
      if (completeReq) begin
        valid_out    <= 1'b1;
        pc_out       <= reqPc;
        dst_out      <= reqDst;
        regwrite_out <= reqRegwrite;
        result_out   <= reqWrite ? reqAddr : loadValue;
      end else if (state == IDLE && valid_in && !flush && !captureReq) begin
        valid_out    <= 1'b1;
        pc_out       <= pc_in;
        dst_out      <= dst_in;
        result_out   <= alu_in;
        misalign_out <= memOp;
        regwrite_out <= memOp ? 1'b0 : regwrite_in;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized
// ALU/load/store traffic against an arithmetic reference model.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid_in;
  logic [63:0] pc_in, alu_in, srcb_in;
  logic [4:0]  dst_in;
  logic        regwrite_in, mem_read, mem_write, mem_unsigned, flush;
  logic [1:0]  msize;
  logic        dreq_valid, dreq_write;
  logic [63:0] dreq_addr, dreq_data;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        stall_m, valid_out, regwrite_out, misalign_out;
  logic [63:0] pc_out, result_out;
  logic [4:0]  dst_out;

  int tests  = 0;
  int failed = 0;

  memory_stage dut (
    .clk(clk), .resetn(resetn), .valid_in(valid_in), .pc_in(pc_in),
    .alu_in(alu_in), .srcb_in(srcb_in), .dst_in(dst_in),
    .regwrite_in(regwrite_in), .mem_read(mem_read), .mem_write(mem_write),
    .msize(msize), .mem_unsigned(mem_unsigned), .flush(flush),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data), .dreq_write(dreq_write),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .stall_m(stall_m), .valid_out(valid_out), .pc_out(pc_out),
    .dst_out(dst_out), .regwrite_out(regwrite_out), .result_out(result_out),
    .misalign_out(misalign_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic modelAligned(input logic [63:0] addr, input logic [1:0] size);
    int off;
    off = int'(addr[2:0]);
    return (off % (1 << size)) == 0;
  endfunction

  function automatic logic [7:0] modelStrobe(input logic [63:0] addr, input logic [1:0] size);
    logic [15:0] m;
    m = 16'((1 << (1 << size)) - 1) << addr[2:0];
    return m[7:0];
  endfunction

  function automatic logic [63:0] modelLoad(input logic [63:0] addr, input logic [1:0] size,
                                            input logic uns, input logic [63:0] data);
    int nbytes;
    logic [63:0] v, keep;
    nbytes = 1 << size;
    v = data >> (8 * int'(addr[2:0]));
    if (nbytes == 8) return v;
    keep = (64'd1 << (8 * nbytes)) - 64'd1;
    v = v & keep;
    if (!uns && v[8 * nbytes - 1]) v = v | ~keep;
    return v;
  endfunction

  task automatic setIdle();
    valid_in = 0; mem_read = 0; mem_write = 0; flush = 0;
    regwrite_in = 0; dresp_data_ok = 0;
  endtask

  // Entered #1 after a rising edge with the stage in IDLE; leaves #1 after the
  // edge that produces this instruction's writeback output.
  task automatic runOp(input string tag, input logic isRead, input logic isWrite,
                       input logic [1:0] size, input logic uns, input logic [63:0] pc,
                       input logic [63:0] addr, input logic [63:0] srcb, input logic [4:0] dst,
                       input logic regw, input int lat, input logic [63:0] rdata);
    logic isMem, al;
    logic [63:0] expRes;
    valid_in = 1; pc_in = pc; alu_in = addr; srcb_in = srcb; dst_in = dst;
    regwrite_in = regw; mem_read = isRead; mem_write = isWrite; msize = size;
    mem_unsigned = uns; flush = 0; dresp_data_ok = 0; dresp_data = ~rdata;
    isMem = isRead | isWrite;
    al = modelAligned(addr, size);
    #1;
    if (!isMem || !al) begin
      check({tag, " stall"}, stall_m, 0);
      check({tag, " noreq"}, dreq_valid, 0);
      @(posedge clk); #1;
      check({tag, " valid"}, valid_out, 1);
      check({tag, " result"}, result_out, addr);
      check({tag, " pc"}, pc_out, pc);
      check({tag, " dst"}, dst_out, dst);
      check({tag, " misalign"}, misalign_out, isMem);
      check({tag, " regwrite"}, regwrite_out, isMem ? 1'b0 : regw);
      check({tag, " noreq_after"}, dreq_valid, 0);
    end else begin
      check({tag, " stall_cap"}, stall_m, 1);
      check({tag, " noreq_cap"}, dreq_valid, 0);
      @(posedge clk); #1;
      check({tag, " bubble_cap"}, valid_out, 0);
      for (int c = 0; c <= lat; c++) begin
        dresp_data_ok = (c == lat);
        dresp_data = (c == lat) ? rdata : ~rdata;
        #1;
        check({tag, " dreq_valid"}, dreq_valid, 1);
        check({tag, " dreq_addr"}, dreq_addr, addr);
        check({tag, " dreq_size"}, dreq_size, size);
        check({tag, " dreq_write"}, dreq_write, isWrite);
        if (isWrite) begin
          check({tag, " dreq_strobe"}, dreq_strobe, modelStrobe(addr, size));
          check({tag, " dreq_data"}, dreq_data, srcb << (8 * int'(addr[2:0])));
        end
        check({tag, " stall_wait"}, stall_m, (c != lat));
        @(posedge clk); #1;
        if (c < lat) check({tag, " bubble_wait"}, valid_out, 0);
      end
      dresp_data_ok = 0;
      expRes = isWrite ? addr : modelLoad(addr, size, uns, rdata);
      check({tag, " valid"}, valid_out, 1);
      check({tag, " result"}, result_out, expRes);
      check({tag, " pc"}, pc_out, pc);
      check({tag, " dst"}, dst_out, dst);
      check({tag, " regwrite"}, regwrite_out, regw);
      check({tag, " misalign"}, misalign_out, 0);
    end
  endtask

  initial begin
    logic [63:0] addr, rdata, srcb;
    logic [1:0]  size;
    int kind;

    // Reset with an ALU op already presented; nothing may leave reset early.
    resetn = 0; setIdle();
    pc_in = 64'h100; alu_in = 64'h55; srcb_in = 0; dst_in = 5'd3; msize = 0;
    mem_unsigned = 0; dresp_data = 0; valid_in = 1; regwrite_in = 1;
    #3;
    check("rst valid_out", valid_out, 0);
    check("rst dreq_valid", dreq_valid, 0);
    check("rst pc_out", pc_out, 0);
    check("rst result_out", result_out, 0);
    check("rst regwrite_out", regwrite_out, 0);
    check("rst misalign_out", misalign_out, 0);
    check("rst dreq_strobe", dreq_strobe, 0);
    #10;
    check("rst held over edge", valid_out, 0);
    resetn = 1;
    #1;
    check("rst release no early out", valid_out, 0);
    @(posedge clk); #1;
    check("first edge valid", valid_out, 1);
    check("first edge pc", pc_out, 64'h100);
    check("first edge regwrite", regwrite_out, 1);

    // Signed load byte, data_ok in first WAIT cycle.
    runOp("lb", 1, 0, 2'd0, 0, 64'h200, 64'h1003, 0, 5'd7, 1, 0, 64'h00000000_80000000);
    // Store half held for five WAIT cycles.
    runOp("sh", 0, 1, 2'd1, 0, 64'h204, 64'h2006, 64'h1234, 5'd0, 0, 4, 64'hDEAD);
    // Misaligned word load.
    runOp("lw_mis", 1, 0, 2'd2, 0, 64'h208, 64'h2002, 0, 5'd9, 1, 0, 0);

    // ALU, load, ALU back-to-back: valid_out 1,0,1,1 and one stall cycle.
    runOp("b2b alu0", 0, 0, 2'd0, 0, 64'h300, 64'hAAAA, 0, 5'd1, 1, 0, 0);
    runOp("b2b ld", 1, 0, 2'd3, 0, 64'h304, 64'h5000, 0, 5'd2, 1, 0, 64'h0123456789ABCDEF);
    runOp("b2b alu1", 0, 0, 2'd0, 0, 64'h308, 64'hBBBB, 0, 5'd3, 1, 0, 0);

    // Idle cycle with stray data_ok is ignored.
    setIdle(); dresp_data_ok = 1;
    @(posedge clk); #1;
    check("idle data_ok valid_out", valid_out, 0);
    check("idle data_ok regwrite", regwrite_out, 0);
    check("idle data_ok dreq_valid", dreq_valid, 0);
    dresp_data_ok = 0;

    // Flush in IDLE: neither an ALU op nor a memory op proceeds.
    valid_in = 1; mem_read = 1; msize = 2'd2; alu_in = 64'h6000; flush = 1; regwrite_in = 1;
    #1;
    check("flush idle stall", stall_m, 0);
    @(posedge clk); #1;
    check("flush idle valid_out", valid_out, 0);
    check("flush idle dreq_valid", dreq_valid, 0);

    // Flush in the second WAIT cycle; data_ok arrives three cycles later.
    flush = 0; mem_read = 1; msize = 2'd2; alu_in = 64'h3000; pc_in = 64'h400;
    #1;
    check("fl capture stall", stall_m, 1);
    @(posedge clk); #1;
    check("fl wait1 dreq_valid", dreq_valid, 1);
    check("fl wait1 stall", stall_m, 1);
    @(posedge clk); #1;
    flush = 1; #1;
    check("fl wait2 stall", stall_m, 0);
    check("fl wait2 dreq_valid", dreq_valid, 1);
    @(posedge clk); #1;
    setIdle(); #1;
    check("fl drain1 dreq_valid", dreq_valid, 1);
    check("fl drain1 valid_out", valid_out, 0);
    check("fl drain1 stall", stall_m, 0);
    @(posedge clk); #1;
    valid_in = 1; mem_write = 1; msize = 2'd3; alu_in = 64'h3100; srcb_in = 64'h77; pc_in = 64'h410;
    #1;
    check("fl drain2 stall newop", stall_m, 1);
    check("fl drain2 dreq_addr held", dreq_addr, 64'h3000);
    check("fl drain2 valid_out", valid_out, 0);
    @(posedge clk); #1;
    dresp_data_ok = 1; dresp_data = 64'hFFFF_FFFF; #1;
    check("fl drain3 dreq_valid", dreq_valid, 1);
    check("fl drain3 stall", stall_m, 1);
    @(posedge clk); #1;
    dresp_data_ok = 0;
    check("fl done valid_out", valid_out, 0);
    runOp("fl sd", 0, 1, 2'd3, 0, 64'h410, 64'h3100, 64'h77, 5'd0, 0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 2));
      size = 2'($urandom_range(0, 3));
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr[2:0] = addr[2:0] & 3'(~((1 << size) - 1));
      rdata = {$urandom, $urandom};
      srcb = {$urandom, $urandom};
      runOp($sformatf("rnd%0d", i), kind == 1, kind == 2, size, 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, addr, srcb, 5'($urandom), (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), rdata);
      if ($urandom_range(0, 4) == 0) begin
        setIdle();
        @(posedge clk); #1;
        check($sformatf("rnd%0d gap", i), valid_out, 0);
      end
    end

    // Asynchronous reset while a transaction is outstanding.
    runOp("pre_rst", 0, 0, 2'd0, 0, 64'h900, 64'h1111, 0, 5'd4, 1, 0, 0);
    valid_in = 1; mem_read = 0; mem_write = 1; msize = 2'd3; alu_in = 64'h4008;
    srcb_in = 64'hCAFE; pc_in = 64'h904; regwrite_in = 0;
    #1;
    @(posedge clk); #1;
    check("rstw in wait", dreq_valid, 1);
    #2 resetn = 0;
    #1;
    check("rstw dreq_valid", dreq_valid, 0);
    check("rstw dreq_addr", dreq_addr, 0);
    check("rstw dreq_data", dreq_data, 0);
    check("rstw dreq_strobe", dreq_strobe, 0);
    check("rstw dreq_size", dreq_size, 0);
    check("rstw dreq_write", dreq_write, 0);
    check("rstw valid_out", valid_out, 0);
    check("rstw pc_out", pc_out, 0);
    check("rstw dst_out", dst_out, 0);
    check("rstw result_out", result_out, 0);
    setIdle();
    @(negedge clk);
    resetn = 1;
    @(posedge clk); #1;
    check("post rst valid_out", valid_out, 0);
    check("post rst dreq_valid", dreq_valid, 0);
    runOp("post rst alu", 0, 0, 2'd0, 0, 64'hA00, 64'h2222, 0, 5'd5, 1, 0, 0);
    setIdle();
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
